// File: rtl/multiphase_pulse_gen.sv
// Non-overlapping multi-phase pulse generator: PHASES one-hot strobes with
// programmable width and dead time, free-running or as a counted burst.
module multiphase_pulse_gen #(
  parameter int                PHASES     = 4,
  parameter int                DW         = 8,
  parameter int                CW         = 8,
  parameter logic [PHASES-1:0] MERGE_MASK = PHASES'(4'b0110)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              enable,
  input  logic              start,
  input  logic              burst_mode,
  input  logic [DW-1:0]     div,
  input  logic [DW-1:0]     gap,
  input  logic [CW-1:0]     burst_len,
  output logic [PHASES-1:0] phase,
  output logic              p_merge,
  output logic              active,
  output logic              done,
  output logic [CW-1:0]     frame_cnt
);

  localparam int             IW   = (PHASES > 2) ? $clog2(PHASES) : 1;
  localparam logic [IW-1:0]  LAST = IW'(PHASES - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]     div_s_q, div_s_d, gap_s_q, gap_s_d;
  logic              mode_s_q, mode_s_d;
  logic [CW-1:0]     blen_s_q, blen_s_d;
  logic [PHASES-1:0] phase_q, phase_d;
  logic              p_merge_q, p_merge_d;
  logic              done_q, done_d;
  logic              on_d;
  logic [CW-1:0]     target;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    div_s_d     = div_s_q;
    gap_s_d     = gap_s_q;
    mode_s_d    = mode_s_q;
    blen_s_d    = blen_s_q;
    done_d      = 1'b0;
    on_d        = 1'b0;
    target      = (blen_s_q == '0) ? CW'(1) : blen_s_q;
    case (state_q)
      IDLE: begin
        if (burst_mode ? start : enable) begin
          div_s_d     = div;
          gap_s_d     = gap;
          mode_s_d    = burst_mode;
          blen_s_d    = burst_len;
          frame_cnt_d = '0;
          idx_d       = '0;
          cnt_d       = '0;
          state_d     = PULSE;
          on_d        = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q != div_s_q) begin
          cnt_d = cnt_q + DW'(1);
          on_d  = 1'b1;
        end else begin
          cnt_d = '0;
          if (idx_q != LAST) begin
            idx_d = idx_q + IW'(1);
            if (gap_s_q != '0) state_d = GAP;
            else               on_d    = 1'b1;
          end else begin
            // Frame complete: stop decision is taken only here, so enable
            // dropping mid-frame lets the frame finish.
            frame_cnt_d = frame_cnt_q + CW'(1);
            idx_d       = '0;
            if (mode_s_q ? (frame_cnt_q + CW'(1) == target) : !enable) begin
              state_d = IDLE;
              done_d  = mode_s_q;
            end else if (gap_s_q != '0) begin
              state_d = GAP;
            end else begin
              on_d = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (cnt_q == gap_s_q - DW'(1)) begin
          cnt_d   = '0;
          state_d = PULSE;
          on_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase bits decoded from a single index, so they can never be multi-hot.
  for (genvar i = 0; i < PHASES; i++) begin : g_phase
    assign phase_d[i] = on_d && (idx_d == IW'(i));
  end

  assign p_merge_d = |(phase_d & MERGE_MASK);

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      div_s_q     <= '0;
      gap_s_q     <= '0;
      mode_s_q    <= 1'b0;
      blen_s_q    <= '0;
      phase_q     <= '0;
      p_merge_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      div_s_q     <= div_s_d;
      gap_s_q     <= gap_s_d;
      mode_s_q    <= mode_s_d;
      blen_s_q    <= blen_s_d;
      phase_q     <= phase_d;
      p_merge_q   <= p_merge_d;
      done_q      <= done_d;
    end
  end

  assign phase     = phase_q;
  assign p_merge   = p_merge_q;
  assign active    = (state_q != IDLE);
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_multiphase_pulse_gen.sv
// Directed bench for multiphase_pulse_gen: vector table plus hand sequences
// for gap timing, graceful stop, shadowing and mid-run clear.
module tb_multiphase_pulse_gen;

  logic       clock = 1'b0;
  logic       clear, enable, start, burst_mode;
  logic [7:0] div, gap, burst_len;
  logic [3:0] phase;
  logic       p_merge, active, done;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  multiphase_pulse_gen dut (
    .clock(clock), .clear(clear), .enable(enable), .start(start),
    .burst_mode(burst_mode), .div(div), .gap(gap), .burst_len(burst_len),
    .phase(phase), .p_merge(p_merge), .active(active), .done(done),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic       clr, en, st, bm;
    logic [7:0] dv, gp, bl;
    logic [3:0] ph;
    logic       mg, ac, dn;
    logic [7:0] fc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic clr, en, st, bm, input logic [7:0] dv, gp, bl,
                     input logic [3:0] ph, input logic mg, ac, dn, input logic [7:0] fc);
    vec_t v;
    v = '{clr, en, st, bm, dv, gp, bl, ph, mg, ac, dn, fc};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int idx, input logic [3:0] ph,
                           input logic mg, ac, dn, input logic [7:0] fc);
    check({tag, ".phase"},     idx, 32'(phase),     32'(ph));
    check({tag, ".p_merge"},   idx, 32'(p_merge),   32'(mg));
    check({tag, ".active"},    idx, 32'(active),    32'(ac));
    check({tag, ".done"},      idx, 32'(done),      32'(dn));
    check({tag, ".frame_cnt"}, idx, 32'(frame_cnt), 32'(fc));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b1; enable = 1'b0; start = 1'b0; burst_mode = 1'b0;
    div = '0; gap = '0; burst_len = '0;

    // Continuous, div=0 gap=0, then graceful stop.
    add(1,0,0,0, 0,0,0, 4'b0000,0,0,0, 0);
    add(0,1,0,0, 0,0,0, 4'b0001,0,1,0, 0);
    add(0,1,0,0, 0,0,0, 4'b0010,1,1,0, 0);
    add(0,1,0,0, 0,0,0, 4'b0100,1,1,0, 0);
    add(0,1,0,0, 0,0,0, 4'b1000,0,1,0, 0);
    add(0,1,0,0, 0,0,0, 4'b0001,0,1,0, 1);
    add(0,1,0,0, 0,0,0, 4'b0010,1,1,0, 1);
    add(0,1,0,0, 0,0,0, 4'b0100,1,1,0, 1);
    add(0,1,0,0, 0,0,0, 4'b1000,0,1,0, 1);
    add(0,1,0,0, 0,0,0, 4'b0001,0,1,0, 2);
    add(0,0,0,0, 0,0,0, 4'b0010,1,1,0, 2);
    add(0,0,0,0, 0,0,0, 4'b0100,1,1,0, 2);
    add(0,0,0,0, 0,0,0, 4'b1000,0,1,0, 2);
    add(0,0,0,0, 0,0,0, 4'b0000,0,0,0, 3);
    add(0,0,0,0, 0,0,0, 4'b0000,0,0,0, 3);
    // Burst: div=1 gap=0 len=2; a second start and input changes mid-run are ignored.
    add(0,0,1,1, 1,0,2, 4'b0001,0,1,0, 0);
    add(0,0,0,1, 1,0,2, 4'b0001,0,1,0, 0);
    add(0,0,0,1, 1,0,2, 4'b0010,1,1,0, 0);
    add(0,0,0,1, 1,0,2, 4'b0010,1,1,0, 0);
    add(0,0,0,1, 1,0,2, 4'b0100,1,1,0, 0);
    add(0,0,1,1, 1,0,2, 4'b0100,1,1,0, 0);
    add(0,1,0,0, 5,3,7, 4'b1000,0,1,0, 0);
    add(0,1,0,0, 5,3,7, 4'b1000,0,1,0, 0);
    add(0,0,0,1, 1,0,2, 4'b0001,0,1,0, 1);
    add(0,0,0,1, 1,0,2, 4'b0001,0,1,0, 1);
    add(0,0,0,1, 1,0,2, 4'b0010,1,1,0, 1);
    add(0,0,0,1, 1,0,2, 4'b0010,1,1,0, 1);
    add(0,0,0,1, 1,0,2, 4'b0100,1,1,0, 1);
    add(0,0,0,1, 1,0,2, 4'b0100,1,1,0, 1);
    add(0,0,0,1, 1,0,2, 4'b1000,0,1,0, 1);
    add(0,0,0,1, 1,0,2, 4'b1000,0,1,0, 1);
    add(0,0,0,1, 1,0,2, 4'b0000,0,0,1, 2);
    add(0,0,0,1, 1,0,2, 4'b0000,0,0,0, 2);

    foreach (tbl[i]) begin
      clear = tbl[i].clr; enable = tbl[i].en; start = tbl[i].st;
      burst_mode = tbl[i].bm; div = tbl[i].dv; gap = tbl[i].gp; burst_len = tbl[i].bl;
      step();
      check_out("vec", i, tbl[i].ph, tbl[i].mg, tbl[i].ac, tbl[i].dn, tbl[i].fc);
    end

    // burst_len=0 runs exactly one frame.
    clear = 1'b1; start = 1'b0; enable = 1'b0; step();
    clear = 1'b0; burst_mode = 1'b1; div = 0; gap = 0; burst_len = 0; start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(); start = 1'b0;
      check_out("blen0", c, 4'b0001 << c, (c == 1 || c == 2), 1'b1, 1'b0, 8'd0);
    end
    step(); check_out("blen0_done", 0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd1);
    step(); check_out("blen0_idle", 0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd1);

    // Continuous div=2 gap=1: 16-cycle frame, one dead cycle between pulses.
    clear = 1'b1; step();
    clear = 1'b0; burst_mode = 1'b0; div = 2; gap = 1; enable = 1'b1;
    for (int c = 0; c < 32; c++) begin
      int t;
      logic [3:0] exp_ph;
      step();
      t = c % 16;
      exp_ph = (t % 4 < 3) ? (4'b0001 << (t / 4)) : 4'b0000;
      check("gap.phase", c, 32'(phase), 32'(exp_ph));
      check("gap.frame_cnt", c, 32'(frame_cnt), 32'(c / 16 + ((t == 15) ? 1 : 0)));
      check("gap.onehot", c, 32'($countones(phase) <= 1), 32'd1);
    end

    // Shadowing: div changes mid-run take effect only on the next run.
    clear = 1'b1; step();
    clear = 1'b0; div = 0; gap = 0; enable = 1'b1;
    step(); check_out("shadow", 0, 4'b0001, 1'b0, 1'b1, 1'b0, 8'd0);
    div = 5;
    step(); check_out("shadow", 1, 4'b0010, 1'b1, 1'b1, 1'b0, 8'd0);
    step(); check_out("shadow", 2, 4'b0100, 1'b1, 1'b1, 1'b0, 8'd0);
    step(); check_out("shadow", 3, 4'b1000, 1'b0, 1'b1, 1'b0, 8'd0);
    enable = 1'b0;
    step(); check_out("shadow_stop", 0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd1);
    enable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(); check_out("shadow_w6", c, 4'b0001, 1'b0, 1'b1, 1'b0, 8'd0);
    end
    step(); check_out("shadow_w6", 6, 4'b0010, 1'b1, 1'b1, 1'b0, 8'd0);

    // Clear during GAP aborts the burst with no done pulse.
    clear = 1'b1; enable = 1'b0; step();
    clear = 1'b0; burst_mode = 1'b1; div = 0; gap = 3; burst_len = 2; start = 1'b1;
    step(); start = 1'b0;
    check_out("clr_run", 0, 4'b0001, 1'b0, 1'b1, 1'b0, 8'd0);
    step(); check_out("clr_gap", 0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0);
    clear = 1'b1;
    step(); check_out("clr_now", 0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(); check_out("clr_idle", c, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    end
    start = 1'b1;
    step(); start = 1'b0;
    check_out("clr_restart", 0, 4'b0001, 1'b0, 1'b1, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiphase_pulse_gen.md
Name: multiphase_pulse_gen

Overview:
Parametrised, non-overlapping multi-phase pulse generator derived from the system clock. It produces PHASES one-hot phase pulses with programmable width and dead time. A merged output is the OR of a selectable subset of phases. It runs either free-running while enabled or as a counted burst, and feeds sequencing logic that needs ordered, non-overlapping strobes.

Parameters:
PHASES, 4, number of output phases (2..16)
DW, 8, width of div and gap settings
CW, 8, width of burst_len and frame_cnt
MERGE_MASK, 4'b0110 (PHASES bits), phases ORed onto p_merge

Ports:
clock  input  1  system clock; all logic on posedge
clear  input  1  synchronous active-high reset
enable  input  1  continuous mode: run while high
start  input  1  burst mode: one-cycle run request
burst_mode  input  1  0 = continuous, 1 = burst
div  input  DW  pulse width minus 1, in clock cycles
gap  input  DW  dead cycles between consecutive pulses
burst_len  input  CW  frames per burst (0 treated as 1)
phase  output  PHASES  one-hot phase pulses, registered
p_merge  output  1  OR of phase bits selected by MERGE_MASK, registered
active  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at burst completion
frame_cnt  output  CW  completed frames in current run, wraps modulo 2^CW

Behaviour:
- Reset (clear high at a posedge): state=IDLE; phase=0, p_merge=0, active=0, done=0, frame_cnt=0; all internal counters 0. clear overrides every other input. Mid-run clear aborts with no done pulse.
- States: IDLE, PULSE, GAP.
- Trigger in IDLE: burst_mode ? start : enable.
  - At the triggering edge, capture div, gap, burst_mode and burst_len into shadow registers. Later input changes are ignored until the next IDLE.
  - At the same edge: frame_cnt=0, phase index=0, state=PULSE, phase=1 (bit 0).
  - Latency is 1 cycle: phase[0] is high in the cycle after the trigger is sampled.
- PULSE: phase[idx] is held high for div_s+1 cycles. At the end of the pulse:
  - If idx != PHASES-1 and gap_s>0: go to GAP.
  - If idx != PHASES-1 and gap_s==0: go to PULSE with idx+1, back-to-back and still one-hot.
  - If idx == PHASES-1: the frame is complete and frame_cnt increments. The next frame (if any) starts at idx 0, via GAP when gap_s>0.
- GAP: phase=0 for gap_s cycles, then PULSE with the next idx.
- Continuous mode: enable is sampled only at frame end.
  - Low at frame end: go to IDLE; the trailing gap is skipped.
  - Dropping mid-frame has no effect until the frame completes (graceful stop).
  - start is ignored.
- Burst mode:
  - Run continues until frame_cnt reaches burst_len_s, or 1 if burst_len_s==0.
  - On the final frame end: go to IDLE, trailing gap skipped. done=1 for exactly the first IDLE cycle; frame_cnt holds its final value.
  - start during a run is ignored. enable is ignored.
- phase is never more than one-hot. p_merge = |(phase & MERGE_MASK), computed from next-state values and registered so it aligns with phase in the same cycle.
- active=1 in PULSE and GAP; 0 in IDLE, including the done cycle.
- frame_cnt is held in IDLE until the next trigger.
- Frame length = PHASES*(div_s+1) + (PHASES-1)*gap_s within a frame, plus gap_s between frames.

Test Plan:
- PHASES=4, div=0, gap=0, continuous, enable held high: phase cycles 0001,0010,0100,1000 with period 4 cycles; p_merge high on the 0010 and 0100 cycles; frame_cnt increments every 4 cycles.
- div=2, gap=1, continuous: each phase high 3 cycles, one all-zero cycle between phases and between frames; 16-cycle frame period; phase never multi-hot.
- Graceful stop: enable drops during phase 1 of a frame. Phases 2 and 3 still complete, then IDLE with active=0. No trailing gap, and frame_cnt is held.
- Burst: burst_mode=1, div=1, gap=0, burst_len=2, start pulsed once. 16 pulse cycles follow, then done=1 for one cycle with frame_cnt=2. A second start mid-run has no effect. burst_len=0 gives exactly 1 frame.
- Shadowing: change div from 0 to 5 mid-run. Pulse widths stay 1 cycle until the next IDLE; the next run uses width 6.
- Reset mid-run: assert clear during a GAP. At the next edge all outputs are 0, state is IDLE, and there is no done pulse. The run restarts only on a fresh trigger.
